matrix_product_checker: RTL and testbench

//  Companion to the 5x5 Gauss-Jordan inverse engine, on its consumer side: streams in matrix A then

---
 rtl/matrix_product_checker.sv | 206 ++++++++++++++++++++
 tb/tb_matrix_product_checker.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_product_checker.sv
// matrix_product_checker
//   Consumer-side self-check for the NxN inverse engine. Streams in A then its
//   candidate inverse B (each row-major, N*N words), forms C = A*B with one
//   multiply-accumulate per cycle, streams C out row-major, and reports
//   whether C is the identity (mod 2^W) and whether any accumulator overflowed W bits.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   LOAD_A  | accepting A words into a_mem
//   LOAD_B  | accepting B words into b_mem
//   MAC     | accumulating A[i][k]*B[k][j] for k = 0..N-1
//   EMIT    | presenting C[i][j] until the consumer takes it
//   DONE    | one-cycle done pulse, results latched
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   in_valid_i/in_ready_o      input element handshake, in_data_i element
//   out_valid_o/out_ready_i    C element handshake, out_data_o = C[i][j] low W bits
//   out_last_o                 marks C[N-1][N-1]
//   done_o                     one-cycle pulse after the last C handshake
//   identity_ok_o, overflow_o  run results, valid from done_o and held

module matrix_product_checker #(
  parameter int N     = 5,
  parameter int W     = 16,
  parameter int ACC_W = 2*W+3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         out_last_o,
  output logic         done_o,
  output logic         identity_ok_o,
  output logic         overflow_o
);

  localparam int NN   = N*N;
  localparam int IDXW = $clog2(NN);
  localparam int CW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDXW-1:0] N_IDX    = IDXW'(N);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NN-1);
  localparam logic [CW-1:0]   N_M1     = CW'(N-1);

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_MAC,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [CW-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             id_q, id_d, ovf_q, ovf_d;
  logic             identity_ok_q, identity_ok_d, overflow_q, overflow_d;

  logic [W-1:0] a_mem [NN];
  logic [W-1:0] b_mem [NN];

  logic [IDXW-1:0]  a_addr, b_addr;
  logic [2*W-1:0]   prod;
  logic [ACC_W-1:0] prod_ext;
  logic             e_last, e_diag;

  // Operand storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset && in_valid_i) begin
      if (state_q == S_LOAD_A) a_mem[idx_q] <= in_data_i;
      if (state_q == S_LOAD_B) b_mem[idx_q] <= in_data_i;
    end
  end

  assign a_addr   = IDXW'(i_q) * N_IDX + IDXW'(k_q);
  assign b_addr   = IDXW'(k_q) * N_IDX + IDXW'(j_q);
  assign prod     = {{W{1'b0}}, a_mem[a_addr]} * {{W{1'b0}}, b_mem[b_addr]};
  assign prod_ext = {{(ACC_W-2*W){1'b0}}, prod};
  assign e_last   = (i_q == N_M1) && (j_q == N_M1);
  assign e_diag   = (i_q == j_q);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    acc_d         = acc_q;
    id_d          = id_q;
    ovf_d         = ovf_q;
    identity_ok_d = identity_ok_q;
    overflow_d    = overflow_q;
    in_ready_o    = 1'b0;
    out_valid_o   = 1'b0;
    out_last_o    = 1'b0;
    done_o        = 1'b0;

    case (state_q)
      S_LOAD_A: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      S_LOAD_B: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            acc_d   = '0;
            id_d    = 1'b1;
            ovf_d   = 1'b0;
            state_d = S_MAC;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        if (k_q == N_M1) begin
          k_d     = '0;
          state_d = S_EMIT;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      S_EMIT: begin
        out_valid_o = 1'b1;
        out_last_o  = e_last;
        if (out_ready_i) begin
          id_d  = id_q & (acc_q[W-1:0] == {{(W-1){1'b0}}, e_diag});
          ovf_d = ovf_q | (|acc_q[ACC_W-1:W]);
          if (e_last) begin
            state_d = S_DONE;
          end else begin
            if (j_q == N_M1) begin
              j_d = '0;
              i_d = i_q + CW'(1);
            end else begin
              j_d = j_q + CW'(1);
            end
            acc_d   = '0;
            k_d     = '0;
            state_d = S_MAC;
          end
        end
      end
      S_DONE: begin
        done_o        = 1'b1;
        identity_ok_d = id_q;
        overflow_d    = ovf_q;
        state_d       = S_LOAD_A;
      end
      default: state_d = S_LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_LOAD_A;
      idx_q         <= '0;
      i_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      acc_q         <= '0;
      id_q          <= 1'b0;
      ovf_q         <= 1'b0;
      identity_ok_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      i_q           <= i_d;
      j_q           <= j_d;
      k_q           <= k_d;
      acc_q         <= acc_d;
      id_q          <= id_d;
      ovf_q         <= ovf_d;
      identity_ok_q <= identity_ok_d;
      overflow_q    <= overflow_d;
    end
  end

  // acc only changes in MAC, so out_data stays stable while EMIT waits.
  assign out_data_o = acc_q[W-1:0];

  // Results are visible during the done pulse itself and held afterwards.
  assign identity_ok_o = (state_q == S_DONE) ? id_q  : identity_ok_q;
  assign overflow_o    = (state_q == S_DONE) ? ovf_q : overflow_q;

endmodule

// File: tb/tb_matrix_product_checker.sv
module tb_matrix_product_checker;
  localparam int N  = 5;
  localparam int W  = 16;
  localparam int NN = N*N;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          done;
  logic          identity_ok;
  logic          overflow;

  matrix_product_checker #(.N(N), .W(W), .ACC_W(2*W+3)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_last_o    (out_last),
    .done_o        (done),
    .identity_ok_o (identity_ok),
    .overflow_o    (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t      sb[$];
  logic [1:0] res_q[$];
  logic [W-1:0] ma [NN];
  logic [W-1:0] mb [NN];

  int           beats_seen = 0;
  logic         exp_done = 1'b0;
  logic         hold_id = 1'b0, hold_ovf = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;
  beat_t        mon_b;
  logic [1:0]   mon_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: plain matrix product in 64-bit integers.
  task automatic push_expected();
    logic id = 1'b1;
    logic ovf = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint unsigned c = 0;
        logic [63:0] cv;
        beat_t b;
        for (int k = 0; k < N; k++)
          c += longint'(ma[i*N+k]) * longint'(mb[k*N+j]);
        cv = c;
        b.data = cv[W-1:0];
        b.last = (i == N-1) && (j == N-1);
        sb.push_back(b);
        if (cv[W-1:0] != ((i == j) ? 16'd1 : 16'd0)) id = 1'b0;
        if ((cv >> W) != 0) ovf = 1'b1;
      end
    res_q.push_back({id, ovf});
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (reset) begin
      exp_done   = 1'b0;
      prev_stall = 1'b0;
      hold_id    = 1'b0;
      hold_ovf   = 1'b0;
    end else begin
      check("done_pulse", done, exp_done);
      if (exp_done) begin
        if (res_q.size() == 0) check("result_expected", 0, 1);
        else begin
          mon_r = res_q.pop_front();
          check("identity_ok", identity_ok, mon_r[1]);
          check("overflow", overflow, mon_r[0]);
          hold_id  = mon_r[1];
          hold_ovf = mon_r[0];
        end
      end else begin
        check("identity_ok_hold", identity_ok, hold_id);
        check("overflow_hold", overflow, hold_ovf);
      end
      exp_done = 1'b0;
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_stable", out_data, prev_data);
        check("stall_last_stable", out_last, prev_last);
      end
      if (out_valid) begin
        check("in_ready_while_out", in_ready, 0);
        if (out_ready) begin
          if (sb.size() == 0) check("stray_out_valid", 1, 0);
          else begin
            mon_b = sb.pop_front();
            check("out_data", out_data, mon_b.data);
            check("out_last", out_last, mon_b.last);
          end
          beats_seen++;
          if (out_last) exp_done = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    res_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_identity_ok", identity_ok, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk); #1;
  endtask

  // mode: 0 ready high, 1 random ready, 2 ready high with a 10-cycle stall at stall_beat.
  task automatic run(input int mode, input int stall_beat, input bit timing,
                     input bit gaps, input bit extra, input int abort_beat);
    int  cyc = 0;
    int  stall_left = 0;
    bit  stalled = 0;
    bit  got = 0;
    bit  aborted = 0;
    push_expected();
    beats_seen = 0;
    for (int w = 0; w < 2*NN; w++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = (w < NN) ? ma[w] : mb[w-NN];
      @(negedge clk);
      check("in_ready_load", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid  = extra;
    in_data   = W'($urandom);
    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    while (cyc < 3000) begin
      @(negedge clk);
      if (timing && cyc < N) check("latency_no_valid", out_valid, 0);
      if (timing && cyc == N) check("latency_valid", out_valid, 1);
      check("in_ready_busy", in_ready, 0);
      if (done) begin got = 1; break; end
      @(posedge clk); #1;
      cyc++;
      if (abort_beat >= 0 && beats_seen == abort_beat && !out_valid) begin
        aborted = 1;
        break;
      end
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      if (mode == 2) begin
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) out_ready = 1'b1;
        end else if (!stalled && beats_seen == stall_beat && out_valid) begin
          out_ready  = 1'b0;
          stall_left = 10;
          stalled    = 1;
        end
      end
    end
    in_valid = 1'b0;
    if (aborted) begin
      repeat (2) @(posedge clk);
      #1 do_reset();
      repeat (10) begin
        @(negedge clk);
        check("post_reset_no_valid", out_valid, 0);
        check("post_reset_no_done", done, 0);
      end
      @(posedge clk); #1;
    end else begin
      if (!got) check("run_timeout", 0, 1);
      if (timing && got) check("run_cycles", cyc, N*N*(N+1));
      @(posedge clk); #1;
      check("beat_count", beats_seen, NN);
      if (mode == 2) check("stall_happened", stalled, 1);
      check("scoreboard_empty", sb.size(), 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic set_fill(input logic [W-1:0] av, input logic [W-1:0] bv);
    for (int i = 0; i < NN; i++) begin ma[i] = av; mb[i] = bv; end
  endtask

  task automatic set_ident();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i*N+j] = (i == j) ? 16'd1 : 16'd0;
        mb[i*N+j] = (i == j) ? 16'd1 : 16'd0;
      end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // 1: identity times identity, latency and cycle count checked
    set_ident();
    run(0, -1, 1, 0, 0, -1);

    // 2: upper-triangular ones times wrap-around inverse
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i*N+j] = (j >= i) ? 16'd1 : 16'd0;
        mb[i*N+j] = (i == j) ? 16'd1 : ((j == i+1) ? 16'hFFFF : 16'd0);
      end
    run(0, -1, 0, 0, 1, -1);

    // 3: all twos times all threes
    set_fill(16'd2, 16'd3);
    run(0, -1, 0, 0, 0, -1);

    // 4: identity with a 10-cycle consumer stall on beat 7
    set_ident();
    run(2, 6, 0, 0, 0, -1);

    // 5: maximum operands
    set_fill(16'hFFFF, 16'hFFFF);
    run(0, -1, 0, 0, 0, -1);

    // 6: abort during MAC of element 12, then test 3 again
    set_fill(16'd2, 16'd3);
    run(0, -1, 0, 0, 0, 11);
    run(0, -1, 1, 0, 0, -1);

    // random matrices with random back-pressure and input gaps
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NN; i++) begin
        ma[i] = W'($urandom);
        mb[i] = (t == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      end
      run(1, -1, 0, 1, t[0], -1);
    end

    // random elementary-matrix inverse pairs: A = I + cE, B = I - cE (mod 2^W)
    for (int t = 0; t < 2; t++) begin
      int r = $urandom_range(0, N-1);
      int c = (r + $urandom_range(1, N-1)) % N;
      logic [W-1:0] v = W'($urandom_range(1, 65535));
      set_ident();
      ma[r*N+c] = v;
      mb[r*N+c] = W'(0) - v;
      run(1, -1, 0, 1, 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
